execute_stage: RTL

EXECUTE_STAGE -- requirements
Module: execute_stage

---
 rtl/execute_stage.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS-style execute stage with iterative mul/div and E/M pipeline register
//
// Purpose: computes the ALU result for the instruction in E, runs MULT/MULTU
// (and DIV/DIVU when EXEC_DIV_EN is defined) on a 32-step iterative unit that
// holds the pipeline through stallE, owns the HI/LO registers, and registers
// everything into the M stage.
//
// Build option: EXEC_DIV_EN - when defined the divider is built; when
// undefined DIV/DIVU retire in one cycle as a NOP and HI/LO are untouched.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   srcAE, srcBE, immE         operands and sign-extended immediate
//   rtE, rdE                   destination register candidates
//   ALUControlE                operation select
//   ALUSrcE .. validE          decoded controls for the instruction in E
//   flushE                     kill the instruction in E
//   stallE                     E cannot advance this cycle
//   writeDataM .. validM       registered M-stage outputs

`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

module execute_stage #(
    parameter int DATA_W = `WORD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    srcAE,
    input  logic [DATA_W-1:0]    srcBE,
    input  logic [DATA_W-1:0]    immE,
    input  logic [`REG_SIZE-1:0] rtE,
    input  logic [`REG_SIZE-1:0] rdE,
    input  logic [3:0]           ALUControlE,
    input  logic                 ALUSrcE,
    input  logic                 regDstE,
    input  logic                 regWriteE,
    input  logic                 memWriteE,
    input  logic                 mem2regE,
    input  logic                 branchE,
    input  logic                 finishE,
    input  logic                 validE,
    input  logic                 flushE,
    output logic                 stallE,
    output logic [DATA_W-1:0]    writeDataM,
    output logic [DATA_W-1:0]    ALUResultM,
    output logic [`REG_SIZE-1:0] writeRegM,
    output logic                 regWriteM,
    output logic                 memWriteM,
    output logic                 mem2regM,
    output logic                 zeroM,
    output logic                 branchM,
    output logic                 finishM,
    output logic                 validM
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam int SH_W  = $clog2(DATA_W);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;
    localparam logic [3:0] OP_MULT  = 4'd12;
    localparam logic [3:0] OP_MULTU = 4'd13;
    localparam logic [3:0] OP_DIV   = 4'd14;
    localparam logic [3:0] OP_DIVU  = 4'd15;

`ifdef EXEC_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]     opb_q;
    logic                  neg_res_q;
    logic [DATA_W-1:0]     hi_q, lo_q;
`ifdef EXEC_DIV_EN
    logic                  div_q;
    logic                  neg_rem_q;
    logic                  divzero_q;
    logic [DATA_W-1:0]     dividend_q;
`endif

    logic [DATA_W-1:0]     op_b;
    logic [`REG_SIZE-1:0]  dest;
    logic                  is_mul, is_div, is_md, signed_op;
    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     a_mag, b_mag;
    logic                  start, last_step;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   step_acc;
    logic [2*DATA_W-1:0]   hilo_d;
    logic [DATA_W-1:0]     alu_res;
    logic                  bubble;

    assign op_b      = ALUSrcE ? immE : srcBE;
    assign dest      = regDstE ? rdE : rtE;
    assign is_mul    = (ALUControlE == OP_MULT) || (ALUControlE == OP_MULTU);
    assign is_div    = (ALUControlE == OP_DIV)  || (ALUControlE == OP_DIVU);
    assign is_md     = is_mul || is_div;
    assign signed_op = (ALUControlE == OP_MULT) || (ALUControlE == OP_DIV);

    // The iterative unit works on magnitudes; signs are re-applied when HI/LO load.
    assign a_neg = signed_op && srcAE[DATA_W-1];
    assign b_neg = signed_op && op_b[DATA_W-1];
    assign a_mag = a_neg ? -srcAE : srcAE;
    assign b_mag = b_neg ? -op_b  : op_b;

    assign start     = (state_q == S_IDLE) && validE && !flushE && (is_mul || (is_div && DIV_EN));
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));
    assign stallE    = reset && (start || (state_q == S_BUSY));

    // Shift-add multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);

`ifdef EXEC_DIV_EN
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] div_next;
    logic [DATA_W-1:0]   quo_raw, rem_raw;

    // Restoring divide: acc holds {remainder, dividend bits / quotient bits}.
    assign div_diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, opb_q};
    assign div_next = div_diff[DATA_W] ? {acc_q[2*DATA_W-2:0], 1'b0}
                                       : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    assign step_acc = div_q ? div_next : {mul_sum, acc_q[DATA_W-1:1]};
    assign quo_raw  = step_acc[DATA_W-1:0];
    assign rem_raw  = step_acc[2*DATA_W-1:DATA_W];

    always_comb begin
        hilo_d = neg_res_q ? -step_acc : step_acc;
        if (div_q) begin
            if (divzero_q) begin
                hilo_d = {dividend_q, {DATA_W{1'b1}}};
            end else begin
                hilo_d[2*DATA_W-1:DATA_W] = neg_rem_q ? -rem_raw : rem_raw;
                hilo_d[DATA_W-1:0]        = neg_res_q ? -quo_raw : quo_raw;
            end
        end
    end
`else
    assign step_acc = {mul_sum, acc_q[DATA_W-1:1]};
    assign hilo_d   = neg_res_q ? -step_acc : step_acc;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_BUSY;
            S_BUSY: begin
                if (flushE)         state_d = S_IDLE;
                else if (last_step) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
`ifdef EXEC_DIV_EN
            div_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            divzero_q  <= 1'b0;
            dividend_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (start) begin
                cnt_q     <= '0;
                acc_q     <= {{DATA_W{1'b0}}, a_mag};
                opb_q     <= b_mag;
                neg_res_q <= a_neg ^ b_neg;
`ifdef EXEC_DIV_EN
                div_q      <= is_div;
                neg_rem_q  <= a_neg;
                divzero_q  <= (op_b == '0);
                dividend_q <= srcAE;
`endif
            end else if ((state_q == S_BUSY) && !flushE) begin
                cnt_q <= cnt_q + 1'b1;
                acc_q <= step_acc;
                // HI/LO only change on a completed operation; aborts leave them intact.
                if (last_step) begin
                    hi_q <= hilo_d[2*DATA_W-1:DATA_W];
                    lo_q <= hilo_d[DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            OP_AND:  alu_res = srcAE & op_b;
            OP_OR:   alu_res = srcAE | op_b;
            OP_ADD:  alu_res = srcAE + op_b;
            OP_XOR:  alu_res = srcAE ^ op_b;
            OP_NOR:  alu_res = ~(srcAE | op_b);
            OP_MFHI: alu_res = hi_q;
            OP_SUB:  alu_res = srcAE - op_b;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(srcAE) < $signed(op_b))};
            OP_SLL:  alu_res = srcAE << op_b[SH_W-1:0];
            OP_SRL:  alu_res = srcAE >> op_b[SH_W-1:0];
            OP_SRA:  alu_res = $signed(srcAE) >>> op_b[SH_W-1:0];
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    assign bubble = stallE || flushE || !validE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeDataM <= '0;
            ALUResultM <= '0;
            writeRegM  <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            mem2regM   <= 1'b0;
            zeroM      <= 1'b0;
            branchM    <= 1'b0;
            finishM    <= 1'b0;
            validM     <= 1'b0;
        end else if (bubble) begin
            writeDataM <= '0;
            ALUResultM <= '0;
            writeRegM  <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            mem2regM   <= 1'b0;
            zeroM      <= 1'b0;
            branchM    <= 1'b0;
            finishM    <= 1'b0;
            validM     <= 1'b0;
        end else begin
            writeDataM <= srcBE;
            ALUResultM <= alu_res;
            writeRegM  <= dest;
            regWriteM  <= regWriteE && !is_md;
            memWriteM  <= memWriteE && !is_md;
            mem2regM   <= mem2regE;
            zeroM      <= (alu_res == '0);
            branchM    <= branchE;
            finishM    <= finishE;
            validM     <= 1'b1;
        end
    end

endmodule
